// File: rtl/fwrisc_branch_unit.sv
// ---------------------------------------------------------------------------
// fwrisc_branch_unit
//
// Conditional-branch resolver for the fwrisc core. The unit accepts one
// RV32I branch request at a time and forwards the two register operands to
// an external comparator, together with the compare operation. CMP_WAIT
// cycles later it samples the comparator's 1-bit result. It then returns the
// taken flag and the resolved next PC to the fetch/sequencer.
//
// Parameters
//   CMP_WAIT      cycles from driving comparator operands to sampling
//                 cmp_out (1..15)
//
// Ports
//   clock         single clock
//   reset         asynchronous, active-low reset
//   req_valid     branch request valid
//   req_ready     unit can accept a request (registered, high only in IDLE)
//   req_funct3    RV32I branch funct3
//   req_rs1       operand A
//   req_rs2       operand B
//   req_pc        PC of the branch instruction
//   req_imm       sign-extended branch offset
//   cmp_in_a      comparator operand A (registered)
//   cmp_in_b      comparator operand B (registered)
//   cmp_op        comparator op: 0=EQ, 1=LT (signed), 2=LTU
//   cmp_out       comparator result
//   rsp_valid     response valid
//   rsp_ready     consumer accepts response
//   rsp_taken     branch taken
//   rsp_next_pc   resolved next PC (pc+imm if taken, else pc+4, modulo 2^32)
//   rsp_illegal   funct3 was 010 or 011
//   rsp_misalign  taken target has bit 1 set; driven only when
//                 FWRISC_BRANCH_MISALIGN_EN is defined, otherwise tied to 0
//
// Build option
//   FWRISC_BRANCH_MISALIGN_EN  enables the registered rsp_misalign flag
// ---------------------------------------------------------------------------
module fwrisc_branch_unit #(
    parameter int CMP_WAIT = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_rs1,
    input  logic [31:0] req_rs2,
    input  logic [31:0] req_pc,
    input  logic [31:0] req_imm,
    output logic [31:0] cmp_in_a,
    output logic [31:0] cmp_in_b,
    output logic [1:0]  cmp_op,
    input  logic        cmp_out,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_taken,
    output logic [31:0] rsp_next_pc,
    output logic        rsp_illegal,
    output logic        rsp_misalign
);

    generate
        if (CMP_WAIT < 1 || CMP_WAIT > 15) begin : g_bad_cmp_wait
            $error("fwrisc_branch_unit: CMP_WAIT must be in the range 1..15");
        end
    endgenerate

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [1:0] OP_EQ  = 2'd0;
    localparam logic [1:0] OP_LT  = 2'd1;
    localparam logic [1:0] OP_LTU = 2'd2;

    localparam logic [3:0] CNT_LOAD = 4'(CMP_WAIT - 1);

    // funct3[2:1] selects the comparison; 01x is not a branch and falls
    // back to EQ so the comparator still sees a defined op.
    function automatic logic [1:0] decode_op(input logic [2:0] f3);
        case (f3[2:1])
            2'b10:   decode_op = OP_LT;
            2'b11:   decode_op = OP_LTU;
            default: decode_op = OP_EQ;
        endcase
    endfunction

    function automatic logic is_illegal(input logic [2:0] f3);
        is_illegal = (f3[2:1] == 2'b01);
    endfunction

    // funct3[0] selects the complementary branch (BNE/BGE/BGEU).
    function automatic logic resolve_taken(input logic inv, input logic ill,
                                           input logic cmp);
        resolve_taken = ill ? 1'b0 : (cmp ^ inv);
    endfunction

    logic [1:0]  state;
    logic [3:0]  wait_cnt;

    // Request fields kept for the response; pure data, no reset needed.
    logic [31:0] pc_q;
    logic [31:0] imm_q;
    logic        inv_q;
    logic        illegal_q;

    logic        accept;
    logic        sample;
    logic        taken_now;
    logic [31:0] target_pc;
    logic [31:0] seq_pc;
    logic [31:0] next_pc_now;

    assign accept = req_valid && req_ready;
    assign sample = (state == ST_WAIT) && (wait_cnt == 4'd0);

    assign taken_now   = resolve_taken(inv_q, illegal_q, cmp_out);
    assign target_pc   = pc_q + imm_q;
    assign seq_pc      = pc_q + 32'd4;
    assign next_pc_now = taken_now ? target_pc : seq_pc;

    // Accept stage: capture request fields; later req_* changes are ignored.
    always_ff @(posedge clock) begin
        if (accept) begin
            pc_q      <= req_pc;
            imm_q     <= req_imm;
            inv_q     <= req_funct3[0];
            illegal_q <= is_illegal(req_funct3);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            req_ready   <= 1'b0;
            wait_cnt    <= 4'd0;
            cmp_in_a    <= 32'd0;
            cmp_in_b    <= 32'd0;
            cmp_op      <= OP_EQ;
            rsp_valid   <= 1'b0;
            rsp_taken   <= 1'b0;
            rsp_next_pc <= 32'd0;
            rsp_illegal <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // req_ready rises on the first edge after reset release.
                    req_ready <= 1'b1;
                    if (accept) begin
                        cmp_in_a  <= req_rs1;
                        cmp_in_b  <= req_rs2;
                        cmp_op    <= decode_op(req_funct3);
                        wait_cnt  <= CNT_LOAD;
                        req_ready <= 1'b0;
                        state     <= ST_WAIT;
                    end
                end

                // Compare stage: comparator settles for CMP_WAIT cycles.
                ST_WAIT: begin
                    if (sample) begin
                        rsp_valid   <= 1'b1;
                        rsp_taken   <= taken_now;
                        rsp_next_pc <= next_pc_now;
                        rsp_illegal <= illegal_q;
                        state       <= ST_RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end

                // Response stage: hold all rsp_* until the consumer takes it.
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end

                default: begin
                    state     <= ST_IDLE;
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b0;
                end
            endcase
        end
    end

`ifdef FWRISC_BRANCH_MISALIGN_EN
    // Target is still reported in rsp_next_pc; the consumer raises the trap.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rsp_misalign <= 1'b0;
        end else if (sample) begin
            rsp_misalign <= taken_now && next_pc_now[1];
        end
    end
`else
    assign rsp_misalign = 1'b0;
`endif

endmodule

// File: doc/fwrisc_branch_unit.md
Name: fwrisc_branch_unit

Overview:
- Conditional-branch resolver for the fwrisc core.
- Accepts a branch request (funct3, rs1, rs2, pc, imm) over a valid/ready handshake.
- Acts as the initiator side of the fwrisc comparator interface: drives registered operands and the compare op, then samples the comparator's 1-bit result.
- Returns the taken flag and next PC to the fetch/sequencer over a second valid/ready handshake.

Parameters:
- CMP_WAIT, default 1: cycles between driving comparator operands and sampling cmp_out. Range 1..15; 0 is an elaboration error.

Ports:
- clock  input  1  single clock
- reset  input  1  asynchronous, active-low reset
- req_valid  input  1  branch request valid
- req_ready  output  1  unit can accept a request
- req_funct3  input  3  RV32I branch funct3
- req_rs1  input  32  operand A
- req_rs2  input  32  operand B
- req_pc  input  32  PC of the branch instruction
- req_imm  input  32  sign-extended branch offset
- cmp_in_a  output  32  comparator operand A
- cmp_in_b  output  32  comparator operand B
- cmp_op  output  2  comparator op: 0=EQ, 1=LT (signed), 2=LTU
- cmp_out  input  1  comparator result
- rsp_valid  output  1  response valid
- rsp_ready  input  1  consumer accepts response
- rsp_taken  output  1  branch taken
- rsp_next_pc  output  32  resolved next PC
- rsp_illegal  output  1  funct3 was 010 or 011
- rsp_misalign  output  1  taken target misaligned; optional feature only

Behaviour:
- Reset (reset low, asynchronous):
  - state=IDLE; req_ready=0; rsp_valid=0; rsp_taken=0; rsp_illegal=0; rsp_misalign=0.
  - rsp_next_pc=0; cmp_in_a=0; cmp_in_b=0; cmp_op=0; wait counter=0.
- req_ready is registered:
  - Rises at the first clock edge after reset deasserts.
  - Equals 1 only in IDLE.
- States: IDLE, WAIT, RESP.
- IDLE:
  - On req_valid && req_ready (edge E0), latch pc, imm and funct3.
  - Register cmp_in_a=rs1 and cmp_in_b=rs2.
  - Set cmp_op from funct3: 000/001 -> EQ; 100/101 -> LT; 110/111 -> LTU; 010/011 -> EQ, with the illegal flag latched.
  - Load counter=CMP_WAIT-1; go to WAIT; drop req_ready.
- WAIT:
  - Counter decrements each edge.
  - At the edge where counter==0 (edge E0+CMP_WAIT), sample cmp_out and go to RESP with rsp_valid=1.
- Result decode:
  - taken = cmp_out for funct3 000/100/110.
  - taken = ~cmp_out for funct3 001/101/111.
  - taken = 0 if illegal.
- Next PC:
  - rsp_next_pc = pc+imm if taken, else pc+4.
  - Both sums are 32-bit, modulo 2^32, with no overflow flag.
- Latency: rsp_valid is visible CMP_WAIT cycles after the accept edge. The illegal path uses the same latency.
- RESP:
  - All rsp_* outputs are held stable while rsp_valid && !rsp_ready.
  - On rsp_ready, go to IDLE; rsp_valid=0 and req_ready=1 at that edge.
  - The next request can be accepted at the following edge. Throughput is one branch per CMP_WAIT+2 cycles.
- cmp_in_a, cmp_in_b and cmp_op hold their values until the next accept; they are not cleared.
- Request inputs are ignored outside IDLE. Changes to req_* after acceptance do not affect the response.
- Reset mid-operation: the async clear applies immediately and any in-flight request is discarded.

Optional Feature:
- Macro: FWRISC_BRANCH_MISALIGN_EN.
- Defined:
  - rsp_misalign = taken && rsp_next_pc[1], registered with the other response fields.
  - rsp_next_pc still carries the computed target; the consumer traps.
- Undefined: rsp_misalign is tied to 0 and no misalign logic is generated.

Test Plan:
- BEQ: rs1=rs2=0x1234, pc=0x100, imm=0x20, CMP_WAIT=1 -> cmp_op=0; rsp_valid one cycle after accept; taken=1, next_pc=0x120.
- BLT vs BLTU: rs1=0xFFFFFFFF, rs2=1, pc=0x200, imm=-8:
  - BLT -> taken=1, next_pc=0x1F8.
  - BLTU -> taken=0, next_pc=0x204.
- BGE, not taken, with backpressure: rs1=-5, rs2=3 -> taken=0, next_pc=pc+4. Hold rsp_ready=0 for 5 cycles -> outputs stable and req_ready=0 throughout; accept -> IDLE.
- Illegal funct3=010 and PC wrap: pc=0xFFFFFFFC -> rsp_illegal=1, taken=0, next_pc=0x00000000.
- CMP_WAIT=3, and reset mid-op:
  - rsp_valid exactly 3 cycles after accept.
  - Assert reset in WAIT -> all outputs 0 immediately; req_ready=1 one edge after release.
- With FWRISC_BRANCH_MISALIGN_EN, BNE taken: pc=0x100, imm=0x6 -> next_pc=0x106, rsp_misalign=1. Without the macro -> rsp_misalign=0.
